// File: rtl/cla_bus_master.sv
// rtl/cla_bus_master.sv - bus initiator driving write A / write B / read sum on the CLA adder slave
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   operand request handshake (ready only when idle)
//   req_a, req_b          operand pair, latched on acceptance
//   rsp_valid/rsp_ready   response handshake, held valid until accepted
//   rsp_sum, rsp_error    captured slave result and mismatch flag vs local A+B
//   busy                  high whenever an operation is in flight
//   CS, WR, RD            active-low chip select, write strobe, read strobe (registered)
//   Address, Data         registered bus address and write data
//   Rdata                 slave result input

module cla_bus_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_sum,
    output logic                  rsp_error,
    output logic                  busy,
    output logic                  CS,
    output logic                  WR,
    output logic                  RD,
    output logic [ADD_WIDTH-1:0]  Address,
    output logic [DATA_WIDTH-1:0] Data,
    input  logic [DATA_WIDTH-1:0] Rdata
);

    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_RD_REQ,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  wait_done;
    logic [DATA_WIDTH-1:0] exp_sum;

    logic                  cs_nxt;
    logic                  wr_nxt;
    logic                  rd_nxt;
    logic [ADD_WIDTH-1:0]  addr_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign wait_done = (wait_cnt == '0);

    // Result width equals operand width, so the carry-out is discarded here.
    assign exp_sum   = a_q + b_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (req_valid) state_nxt = S_WR_A;
            S_WR_A:    state_nxt = S_WR_B;
            S_WR_B:    state_nxt = S_RD_REQ;
            S_RD_REQ:  state_nxt = S_RD_WAIT;
            S_RD_WAIT: if (wait_done) state_nxt = S_RESP;
            S_RESP:    if (rsp_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are registered, so their values are decoded from the state
    // being entered. WR_A is only entered from IDLE, where the operands are
    // not latched yet, hence req_a is driven directly.
    always_comb begin
        cs_nxt   = 1'b1;
        wr_nxt   = 1'b1;
        rd_nxt   = 1'b1;
        addr_nxt = '0;
        data_nxt = '0;
        unique case (state_nxt)
            S_WR_A: begin
                cs_nxt   = 1'b0;
                wr_nxt   = 1'b0;
                addr_nxt = '0;
                data_nxt = req_a;
            end
            S_WR_B: begin
                cs_nxt   = 1'b0;
                wr_nxt   = 1'b0;
                addr_nxt = ADD_WIDTH'(1);
                data_nxt = b_q;
            end
            S_RD_REQ: begin
                cs_nxt   = 1'b0;
                rd_nxt   = 1'b0;
                addr_nxt = ADD_WIDTH'(1);
            end
            default: begin
                cs_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            CS        <= 1'b1;
            WR        <= 1'b1;
            RD        <= 1'b1;
            Address   <= '0;
            Data      <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_error <= 1'b0;
            wait_cnt  <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            state     <= state_nxt;
            CS        <= cs_nxt;
            WR        <= wr_nxt;
            RD        <= rd_nxt;
            Address   <= addr_nxt;
            Data      <= data_nxt;
            rsp_valid <= (state_nxt == S_RESP);

            if (state == S_IDLE && req_valid) begin
                a_q <= req_a;
                b_q <= req_b;
            end

            // Counter counts down the remaining RD_WAIT cycles; zero marks the
            // capture cycle.
            if (state == S_RD_REQ) begin
                wait_cnt <= CNT_W'(RD_LATENCY - 1);
            end else if (state == S_RD_WAIT && !wait_done) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end

            if (state == S_RD_WAIT && wait_done) begin
                rsp_sum   <= Rdata;
                rsp_error <= (Rdata != exp_sum);
            end
        end
    end

endmodule

// File: tb/tb_cla_bus_master.sv
// tb/tb_cla_bus_master.sv - directed table-driven bench for cla_bus_master with a model adder slave

module tb_cla_bus_master;

    logic        clock = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_error, busy;
    logic [31:0] req_a, req_b, rsp_sum, data, rdata;
    logic        cs, wr, rd;
    logic [0:0]  address;

    logic        req_valid_3, req_ready_3, rsp_valid_3, rsp_ready_3, rsp_error_3, busy_3;
    logic [31:0] req_a_3, req_b_3, rsp_sum_3, data_3, rdata_3;
    logic        cs_3, wr_3, rd_3;
    logic [0:0]  address_3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    cla_bus_master #(.DATA_WIDTH(32), .ADD_WIDTH(1), .RD_LATENCY(1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_error(rsp_error),
        .busy(busy), .CS(cs), .WR(wr), .RD(rd), .Address(address), .Data(data), .Rdata(rdata)
    );

    cla_bus_master #(.DATA_WIDTH(32), .ADD_WIDTH(1), .RD_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_3), .req_ready(req_ready_3), .req_a(req_a_3), .req_b(req_b_3),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_sum(rsp_sum_3), .rsp_error(rsp_error_3),
        .busy(busy_3), .CS(cs_3), .WR(wr_3), .RD(rd_3), .Address(address_3), .Data(data_3), .Rdata(rdata_3)
    );

    // Slave models: latch operands on write strobes, produce the sum on a read strobe.
    logic [31:0] sa, sb, sa_3, sb_3;
    logic        fault;
    int          rd_cnt = 0;
    int          rd_cnt_3 = 0;

    always @(posedge clock) begin
        if (!cs && !wr) begin
            if (address == 1'b0) sa <= data;
            else                 sb <= data;
        end
        if (!cs && !rd) rdata <= sa + sb + {31'b0, fault};
        if (!rd) rd_cnt <= rd_cnt + 1;
    end

    always @(posedge clock) begin
        if (!cs_3 && !wr_3) begin
            if (address_3 == 1'b0) sa_3 <= data_3;
            else                   sb_3 <= data_3;
        end
        if (!cs_3 && !rd_3) rdata_3 <= sa_3 + sb_3;
        if (!rd_3) rd_cnt_3 <= rd_cnt_3 + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        fault;
        logic [31:0] sum;
        logic        err;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic run_op(input vec_t v);
        int rd0;
        rd0       = rd_cnt;
        fault     = v.fault;
        req_a     = v.a;
        req_b     = v.b;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clock);
        chk("wr_a_cs", cs, 0);       chk("wr_a_wr", wr, 0);   chk("wr_a_rd", rd, 1);
        chk("wr_a_addr", address, 0); chk("wr_a_data", data, v.a);
        chk("wr_a_req_ready", req_ready, 0); chk("wr_a_busy", busy, 1);
        req_valid = 1'b0;
        @(negedge clock);
        chk("wr_b_cs", cs, 0);       chk("wr_b_wr", wr, 0);   chk("wr_b_rd", rd, 1);
        chk("wr_b_addr", address, 1); chk("wr_b_data", data, v.b);
        @(negedge clock);
        chk("rd_cs", cs, 0);         chk("rd_wr", wr, 1);     chk("rd_rd", rd, 0);
        chk("rd_addr", address, 1);  chk("rd_data", data, 0);
        @(negedge clock);
        chk("wait_cs", cs, 1);       chk("wait_rd", rd, 1);   chk("wait_rsp_valid", rsp_valid, 0);
        @(negedge clock);
        chk("resp_valid", rsp_valid, 1);
        chk("resp_sum", rsp_sum, v.sum);
        chk("resp_error", rsp_error, v.err);
        chk("resp_bus_idle", {cs, wr, rd}, 3'b111);
        chk("rd_strobe_count", rd_cnt - rd0, 1);
        for (int i = 0; i < v.hold; i++) begin
            req_valid = 1'b1;
            @(negedge clock);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_sum", rsp_sum, v.sum);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_cs", cs, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_req_ready", req_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_sum_held", rsp_sum, v.sum);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int rd0;

        vecs[0] = '{a: 32'd5,          b: 32'd7,          fault: 1'b0, sum: 32'd12,         err: 1'b0, hold: 0};
        vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'd1,          fault: 1'b0, sum: 32'd0,          err: 1'b0, hold: 0};
        vecs[2] = '{a: 32'h80000000,   b: 32'h80000000,   fault: 1'b0, sum: 32'd0,          err: 1'b0, hold: 0};
        vecs[3] = '{a: 32'd10,         b: 32'd20,         fault: 1'b1, sum: 32'd31,         err: 1'b1, hold: 5};
        vecs[4] = '{a: 32'h12345678,   b: 32'h9ABCDEF0,   fault: 1'b0, sum: 32'hACF13568,   err: 1'b0, hold: 0};
        vecs[5] = '{a: 32'd1000,       b: 32'd2345,       fault: 1'b0, sum: 32'd3345,       err: 1'b0, hold: 0};

        reset = 1'b1;
        fault = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        req_valid_3 = 1'b0; rsp_ready_3 = 1'b0; req_a_3 = '0; req_b_3 = '0;

        repeat (3) @(negedge clock);
        chk("reset_bus", {cs, wr, rd}, 3'b111);
        chk("reset_addr", address, 0);
        chk("reset_data", data, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_sum", rsp_sum, 0);
        chk("reset_rsp_error", rsp_error, 0);
        chk("reset_busy", busy, 0);
        chk("reset_req_ready", req_ready, 1);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_req_ready", req_ready, 1);
        chk("post_reset_bus", {cs, wr, rd}, 3'b111);

        for (int i = 0; i < 6; i++) run_op(vecs[i]);
        req_valid = 1'b0;
        fault = 1'b0;

        // Reset during WR_B aborts the operation without a read strobe.
        req_a = 32'd3; req_b = 32'd4; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        chk("abort_in_wr_b", {cs, wr, address}, 3'b001);
        rd0 = rd_cnt;
        reset = 1'b1;
        @(negedge clock);
        chk("abort_bus_idle", {cs, wr, rd}, 3'b111);
        chk("abort_addr", address, 0);
        chk("abort_data", data, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_no_rd", rd_cnt - rd0, 0);
        chk("abort_rsp_sum_cleared", rsp_sum, 0);
        run_op(vecs[0]);

        // RD_LATENCY = 3 instance: response expected at E6.
        rd0 = rd_cnt_3;
        req_a_3 = 32'd100; req_b_3 = 32'd23; req_valid_3 = 1'b1;
        k = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            k++;
            if (k == 0) req_valid_3 = 1'b0;
            if (rsp_valid_3) break;
        end
        chk("lat3_edge", k, 6);
        chk("lat3_sum", rsp_sum_3, 123);
        chk("lat3_error", rsp_error_3, 0);
        chk("lat3_rd_count", rd_cnt_3 - rd0, 1);
        rsp_ready_3 = 1'b1;
        @(negedge clock);
        rsp_ready_3 = 1'b0;
        chk("lat3_idle", {rsp_valid_3, req_ready_3}, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
